// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: data widths, the Q1..Q4
// phase encoding, STATUS flag bit positions, flag-mask constants and the
// ALU function encoding.
package alu_writeback_pkg;

    localparam int ALU_FUNC_WIDTH   = 5;
    localparam int ALU_DATA_WIDTH   = 8;
    localparam int ALU_STATUS_WIDTH = 3;

    // Instruction phase; the sequencer walks these in order.
    typedef enum logic [1:0] {
        WB_Q1 = 2'd0,
        WB_Q2 = 2'd1,
        WB_Q3 = 2'd2,
        WB_Q4 = 2'd3
    } wb_phase_e;

    // Bit positions inside the {Z,DC,C} STATUS flag vector.
    localparam int FLAG_C  = 0;
    localparam int FLAG_DC = 1;
    localparam int FLAG_Z  = 2;

    // Flags an instruction is allowed to update.
    localparam logic [ALU_STATUS_WIDTH-1:0] WB_MASK_NONE = 3'b000;
    localparam logic [ALU_STATUS_WIDTH-1:0] WB_MASK_Z    = 3'b100;
    localparam logic [ALU_STATUS_WIDTH-1:0] WB_MASK_C    = 3'b001;
    localparam logic [ALU_STATUS_WIDTH-1:0] WB_MASK_ALL  = 3'b111;

    // ALU function encoding; codes beyond FN_BSF are treated as unknown.
    typedef enum logic [ALU_FUNC_WIDTH-1:0] {
        FN_IDLE  = 5'd0,
        FN_ADDWF = 5'd1,
        FN_SUBWF = 5'd2,
        FN_ANDWF = 5'd3,
        FN_COMF  = 5'd4,
        FN_DECF  = 5'd5,
        FN_INCF  = 5'd6,
        FN_IORWF = 5'd7,
        FN_XORWF = 5'd8,
        FN_ANDLW = 5'd9,
        FN_IORLW = 5'd10,
        FN_XORLW = 5'd11,
        FN_RLF   = 5'd12,
        FN_RRF   = 5'd13,
        FN_SWAPF = 5'd14,
        FN_BCF   = 5'd15,
        FN_BSF   = 5'd16
    } alu_func_e;

endpackage

// File: rtl/alu_writeback_if.sv
// Bus between the writeback stage and its environment: instruction fields
// sampled at Q1, ALU result/status, and the W/STATUS/file-write outputs.
// The master side drives instructions, the slave side is the writeback stage.
interface alu_writeback_if
    import alu_writeback_pkg::*;
#(
    parameter int ADDR_W = 5
) ();

    logic                        holdIn;
    logic                        exValid;
    logic [ALU_FUNC_WIDTH-1:0]   funcIn;
    logic                        destF;
    logic [ADDR_W-1:0]           fAddrIn;
    logic                        skipOnZero;
    logic [ALU_DATA_WIDTH-1:0]   aluResultIn;
    logic [ALU_STATUS_WIDTH-1:0] aluStatusIn;

    logic [1:0]                  qPhase;
    logic [ALU_DATA_WIDTH-1:0]   wOut;
    logic [ALU_STATUS_WIDTH-1:0] statusOut;
    logic                        fWrEn;
    logic [ADDR_W-1:0]           fWrAddr;
    logic [ALU_DATA_WIDTH-1:0]   fWrData;
    logic                        skipReq;

    modport master (
        output holdIn, exValid, funcIn, destF, fAddrIn, skipOnZero,
               aluResultIn, aluStatusIn,
        input  qPhase, wOut, statusOut, fWrEn, fWrAddr, fWrData, skipReq
    );

    modport slave (
        input  holdIn, exValid, funcIn, destF, fAddrIn, skipOnZero,
               aluResultIn, aluStatusIn,
        output qPhase, wOut, statusOut, fWrEn, fWrAddr, fWrData, skipReq
    );

endinterface

// File: rtl/alu_writeback_wb_dest_decode.sv
// Combinational destination/flag-mask decoder for the writeback stage.
// Literal ops always target W, bit ops always target the file, IDLE and
// unknown codes go nowhere and touch no flags; everything else follows d.
module wb_dest_decode
    import alu_writeback_pkg::*;
(
    input  logic [ALU_FUNC_WIDTH-1:0]   func_in,
    input  logic                        dest_f,
    output logic                        to_w,
    output logic                        to_file,
    output logic [ALU_STATUS_WIDTH-1:0] flag_mask
);

    // Map function code and d bit to destination and affected flags.
    always_comb begin
        to_w      = 1'b0;
        to_file   = 1'b0;
        flag_mask = WB_MASK_NONE;
        case (func_in)
            FN_ADDWF, FN_SUBWF: begin
                to_w      = ~dest_f;
                to_file   = dest_f;
                flag_mask = WB_MASK_ALL;
            end
            FN_ANDWF, FN_COMF, FN_DECF, FN_INCF, FN_IORWF, FN_XORWF: begin
                to_w      = ~dest_f;
                to_file   = dest_f;
                flag_mask = WB_MASK_Z;
            end
            FN_ANDLW, FN_IORLW, FN_XORLW: begin
                to_w      = 1'b1;
                flag_mask = WB_MASK_Z;
            end
            FN_RLF, FN_RRF: begin
                to_w      = ~dest_f;
                to_file   = dest_f;
                flag_mask = WB_MASK_C;
            end
            FN_SWAPF: begin
                to_w    = ~dest_f;
                to_file = dest_f;
            end
            FN_BCF, FN_BSF: begin
                to_file = 1'b1;
            end
            default: begin
                to_w      = 1'b0;
                to_file   = 1'b0;
                flag_mask = WB_MASK_NONE;
            end
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage following the ALU. Runs the Q1..Q4 phase sequencer,
// holds one pending instruction, latches the ALU result at the Q3->Q4 edge,
// strobes the file write during Q4 and commits W/STATUS at the Q4->Q1 edge.
// Optional feature macro: WB_ZERO_SKIP_EN (skip request on zero result for
// DECFSZ/INCFSZ style instructions).
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int                ADDR_W      = 5,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(3)
) (
    input  logic           clk,
    input  logic           rst,
    alu_writeback_if.slave bus
);

    wb_phase_e                   phase_q, phase_d;

    logic                        pend_valid_q, pend_valid_d;
    logic                        pend_to_w_q, pend_to_w_d;
    logic                        pend_to_file_q, pend_to_file_d;
    logic [ALU_STATUS_WIDTH-1:0] pend_mask_q, pend_mask_d;
    logic [ADDR_W-1:0]           pend_addr_q, pend_addr_d;
    logic                        pend_skip_q, pend_skip_d;

    logic [ALU_DATA_WIDTH-1:0]   result_q, result_d;
    logic [ALU_STATUS_WIDTH-1:0] alu_status_q, alu_status_d;

    logic [ALU_DATA_WIDTH-1:0]   w_q, w_d;
    logic [ALU_STATUS_WIDTH-1:0] flags_q, flags_d;
    logic                        skip_q, skip_d;

    logic                        dec_to_w;
    logic                        dec_to_file;
    logic [ALU_STATUS_WIDTH-1:0] dec_mask;

    logic                        advance;
    logic                        status_hit;
    logic                        skip_capture;
    logic                        skip_hit;
    logic [ALU_STATUS_WIDTH-1:0] flags_commit;

    wb_dest_decode u_dest_decode (
        .func_in   (bus.funcIn),
        .dest_f    (bus.destF),
        .to_w      (dec_to_w),
        .to_file   (dec_to_file),
        .flag_mask (dec_mask)
    );

    assign advance    = ~bus.holdIn;
    assign status_hit = pend_to_file_q && (pend_addr_q == STATUS_ADDR);

`ifdef WB_ZERO_SKIP_EN
    assign skip_capture = bus.skipOnZero;
`else
    // Without the skip feature the pending skip bit stays 0, so skipReq never fires.
    assign skip_capture = 1'b0;
`endif

    assign skip_hit = pend_skip_q && (result_q == '0);

    // Per-flag commit value: masked flags take the ALU status (the ALU wins
    // even over a direct STATUS write), unmasked flags take the written data
    // when the destination is STATUS, otherwise they keep their value.
    genvar gi;
    generate
        for (gi = 0; gi < ALU_STATUS_WIDTH; gi++) begin : g_flag
            assign flags_commit[gi] = pend_mask_q[gi] ? alu_status_q[gi]
                                    : (status_hit ? result_q[gi] : flags_q[gi]);
        end
    endgenerate

    // Next-state logic: everything holds while holdIn is high; otherwise the
    // phase advances and each phase edge performs its one job.
    always_comb begin
        phase_d        = phase_q;
        pend_valid_d   = pend_valid_q;
        pend_to_w_d    = pend_to_w_q;
        pend_to_file_d = pend_to_file_q;
        pend_mask_d    = pend_mask_q;
        pend_addr_d    = pend_addr_q;
        pend_skip_d    = pend_skip_q;
        result_d       = result_q;
        alu_status_d   = alu_status_q;
        w_d            = w_q;
        flags_d        = flags_q;
        skip_d         = skip_q;

        if (advance) begin
            phase_d = wb_phase_e'(phase_q + 2'd1);
            skip_d  = 1'b0;
            case (phase_q)
                WB_Q1: begin
                    pend_valid_d = bus.exValid;
                    if (bus.exValid) begin
                        pend_to_w_d    = dec_to_w;
                        pend_to_file_d = dec_to_file;
                        pend_mask_d    = dec_mask;
                        pend_addr_d    = bus.fAddrIn;
                        pend_skip_d    = skip_capture;
                    end
                end
                WB_Q3: begin
                    result_d     = bus.aluResultIn;
                    alu_status_d = bus.aluStatusIn;
                end
                WB_Q4: begin
                    if (pend_valid_q) begin
                        if (pend_to_w_q) begin
                            w_d = result_q;
                        end
                        flags_d = flags_commit;
                        skip_d  = skip_hit;
                    end
                    pend_valid_d = 1'b0;
                end
                default: begin
                    pend_valid_d = pend_valid_q;
                end
            endcase
        end
    end

    // State registers; reset discards any pending instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q        <= WB_Q1;
            pend_valid_q   <= 1'b0;
            pend_to_w_q    <= 1'b0;
            pend_to_file_q <= 1'b0;
            pend_mask_q    <= WB_MASK_NONE;
            pend_addr_q    <= '0;
            pend_skip_q    <= 1'b0;
            result_q       <= '0;
            alu_status_q   <= '0;
            w_q            <= '0;
            flags_q        <= '0;
            skip_q         <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            pend_valid_q   <= pend_valid_d;
            pend_to_w_q    <= pend_to_w_d;
            pend_to_file_q <= pend_to_file_d;
            pend_mask_q    <= pend_mask_d;
            pend_addr_q    <= pend_addr_d;
            pend_skip_q    <= pend_skip_d;
            result_q       <= result_d;
            alu_status_q   <= alu_status_d;
            w_q            <= w_d;
            flags_q        <= flags_d;
            skip_q         <= skip_d;
        end
    end

    assign bus.qPhase    = phase_q;
    assign bus.wOut      = w_q;
    assign bus.statusOut = flags_q;
    assign bus.fWrEn     = (phase_q == WB_Q4) && pend_valid_q && pend_to_file_q && ~bus.holdIn;
    assign bus.fWrAddr   = pend_addr_q;
    assign bus.fWrData   = result_q;
    assign bus.skipReq   = skip_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback. The bench plays the ALU: for each
// instruction it computes the result/status itself, pushes the expected
// writeback outcome into a scoreboard and pops it when the DUT reaches Q4
// and the following Q1.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

`ifdef WB_ZERO_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_writeback_if #(.ADDR_W(5)) bus ();

    alu_writeback #(.ADDR_W(5), .STATUS_ADDR(5'h03)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] w;
        logic [2:0] st;
        logic       skip;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] m_w;
    logic [2:0] m_st;

    function automatic void bench_decode(input logic [4:0] fn, input logic d,
                                         output logic tw, output logic tf, output logic [2:0] mk);
        tw = 1'b0; tf = 1'b0; mk = 3'b000;
        case (fn)
            FN_ADDWF, FN_SUBWF: begin tw = !d; tf = d; mk = 3'b111; end
            FN_ANDWF, FN_COMF, FN_DECF, FN_INCF, FN_IORWF, FN_XORWF: begin tw = !d; tf = d; mk = 3'b100; end
            FN_ANDLW, FN_IORLW, FN_XORLW: begin tw = 1'b1; mk = 3'b100; end
            FN_RLF, FN_RRF: begin tw = !d; tf = d; mk = 3'b001; end
            FN_SWAPF: begin tw = !d; tf = d; end
            FN_BCF, FN_BSF: tf = 1'b1;
            default: begin tw = 1'b0; tf = 1'b0; mk = 3'b000; end
        endcase
    endfunction

    // Reference ALU; flags the instruction does not own are driven randomly
    // so that masking is exercised.
    function automatic void alu_eval(input logic [4:0] fn, input logic [7:0] f, input logic [2:0] bitn,
                                     input logic [2:0] mk, output logic [7:0] r, output logic [2:0] s);
        logic [8:0] sum;
        logic [4:0] lo;
        logic dcf, cf;
        r = 8'h00; dcf = 1'b0; cf = 1'b0;
        case (fn)
            FN_ADDWF: begin
                sum = {1'b0, f} + {1'b0, m_w};
                lo = {1'b0, f[3:0]} + {1'b0, m_w[3:0]};
                r = sum[7:0]; cf = sum[8]; dcf = lo[4];
            end
            FN_SUBWF: begin
                r = f - m_w; cf = (f >= m_w); dcf = (f[3:0] >= m_w[3:0]);
            end
            FN_ANDWF, FN_ANDLW: r = f & m_w;
            FN_IORWF, FN_IORLW: r = f | m_w;
            FN_XORWF, FN_XORLW: r = f ^ m_w;
            FN_COMF:  r = ~f;
            FN_DECF:  r = f - 8'd1;
            FN_INCF:  r = f + 8'd1;
            FN_RLF:   begin r = {f[6:0], m_st[0]}; cf = f[7]; end
            FN_RRF:   begin r = {m_st[0], f[7:1]}; cf = f[0]; end
            FN_SWAPF: r = {f[3:0], f[7:4]};
            FN_BCF:   r = f & ~(8'h01 << bitn);
            FN_BSF:   r = f | (8'h01 << bitn);
            default:  r = 8'h00;
        endcase
        s = 3'($urandom_range(0, 7));
        if (mk[2]) s[2] = (r == 8'h00);
        if (mk[1]) s[1] = dcf;
        if (mk[0]) s[0] = cf;
    endfunction

    task automatic wait_q1();
        bit found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.qPhase == 2'd0) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_q1: qPhase=%0d, required 0 within 8 cycles", bus.qPhase);
        end
    endtask

    // Issue one instruction at Q1 and check it through Q4 and the commit.
    // hold_cycles>0 freezes the stage in Q4; rst_q3 resets it during Q3.
    task automatic run_instr(input string name, input logic [4:0] fn, input logic d, input logic [4:0] addr,
                             input logic [7:0] f, input logic [2:0] bitn, input logic skp,
                             input int hold_cycles, input bit rst_q3);
        exp_t e, o;
        logic tw, tf;
        logic [2:0] mk, s;
        logic [7:0] r;
        int wr_seen = 0;
        wait_q1();
        bench_decode(fn, d, tw, tf, mk);
        alu_eval(fn, f, bitn, mk, r, s);
        e.wr = tf; e.addr = addr; e.data = r;
        e.w = tw ? r : m_w;
        for (int i = 0; i < 3; i++)
            e.st[i] = mk[i] ? s[i] : ((tf && addr == 5'h03) ? r[i] : m_st[i]);
        e.skip = SKIP_EN && skp && (r == 8'h00);
        if (rst_q3) begin
            e.wr = 1'b0; e.w = 8'h00; e.st = 3'b000; e.skip = 1'b0;
        end
        sb.push_back(e);
        bus.exValid = 1'b1; bus.funcIn = fn; bus.destF = d; bus.fAddrIn = addr;
        bus.skipOnZero = skp; bus.aluResultIn = r; bus.aluStatusIn = s;
        @(posedge clk); @(negedge clk);
        bus.exValid = 1'b0;
        if (bus.fWrEn) wr_seen++;
        @(posedge clk); @(negedge clk);
        if (rst_q3) begin
            rst = 1'b1;
            #1;
            checks++;
            if ({bus.qPhase, bus.wOut, bus.statusOut, bus.fWrEn, bus.fWrAddr, bus.fWrData, bus.skipReq} !== 27'd0) begin
                errors++;
                $display("FAIL %s reset_outputs: q=%0d w=%h st=%b we=%b a=%h d=%h sk=%b, required all zero",
                         name, bus.qPhase, bus.wOut, bus.statusOut, bus.fWrEn, bus.fWrAddr, bus.fWrData, bus.skipReq);
            end
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                #1 if (bus.fWrEn) wr_seen++;
                @(negedge clk);
            end
            o = sb.pop_front();
            checks++;
            if (wr_seen != 0 || bus.wOut !== o.w || bus.statusOut !== o.st) begin
                errors++;
                $display("FAIL %s after_reset: writes=%0d w=%h st=%b, required writes=0 w=%h st=%b",
                         name, wr_seen, bus.wOut, bus.statusOut, o.w, o.st);
            end
            m_w = o.w; m_st = o.st;
            $display("TXN %s fn=%0d reset in Q3, discarded", name, fn);
            return;
        end
        if (bus.fWrEn) wr_seen++;
        @(posedge clk); @(negedge clk);
        checks++;
        if (bus.qPhase !== 2'd3) begin
            errors++;
            $display("FAIL %s q4_phase: qPhase=%0d, required 3", name, bus.qPhase);
        end
        if (hold_cycles > 0) begin
            bus.holdIn = 1'b1;
            #1;
            checks++;
            if (bus.fWrEn !== 1'b0) begin
                errors++;
                $display("FAIL %s hold_wren: fWrEn=%b, required 0", name, bus.fWrEn);
            end
            for (int i = 0; i < hold_cycles; i++) begin
                @(posedge clk); @(negedge clk);
                checks++;
                if (bus.qPhase !== 2'd3 || bus.fWrEn !== 1'b0 || bus.wOut !== m_w || bus.statusOut !== m_st) begin
                    errors++;
                    $display("FAIL %s hold_frozen: q=%0d we=%b w=%h st=%b, required q=3 we=0 w=%h st=%b",
                             name, bus.qPhase, bus.fWrEn, bus.wOut, bus.statusOut, m_w, m_st);
                end
            end
            bus.holdIn = 1'b0;
            #1;
        end
        o = sb.pop_front();
        if (bus.fWrEn) wr_seen++;
        checks++;
        if (bus.fWrEn !== o.wr) begin
            errors++;
            $display("FAIL %s q4_wren: fWrEn=%b, required %b", name, bus.fWrEn, o.wr);
        end
        if (o.wr) begin
            checks++;
            if (bus.fWrAddr !== o.addr || bus.fWrData !== o.data) begin
                errors++;
                $display("FAIL %s q4_write: addr=%h data=%h, required addr=%h data=%h",
                         name, bus.fWrAddr, bus.fWrData, o.addr, o.data);
            end
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (bus.qPhase !== 2'd0 || bus.wOut !== o.w || bus.statusOut !== o.st ||
            bus.skipReq !== o.skip || bus.fWrEn !== 1'b0 || wr_seen != (o.wr ? 1 : 0)) begin
            errors++;
            $display("FAIL %s commit: q=%0d w=%h st=%b sk=%b we=%b writes=%0d, required q=0 w=%h st=%b sk=%b we=0 writes=%0d",
                     name, bus.qPhase, bus.wOut, bus.statusOut, bus.skipReq, bus.fWrEn, wr_seen,
                     o.w, o.st, o.skip, o.wr ? 1 : 0);
        end
        m_w = o.w; m_st = o.st;
        $display("TXN %s fn=%0d d=%0b addr=%h f=%h result=%h w=%h st=%b skip=%b",
                 name, fn, d, addr, f, r, o.w, o.st, o.skip);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.holdIn = 1'b0; bus.exValid = 1'b0; bus.funcIn = '0; bus.destF = 1'b0;
        bus.fAddrIn = '0; bus.skipOnZero = 1'b0; bus.aluResultIn = '0; bus.aluStatusIn = '0;
        m_w = 8'h00; m_st = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.qPhase, bus.wOut, bus.statusOut, bus.fWrEn, bus.fWrAddr, bus.fWrData, bus.skipReq} !== 27'd0) begin
            errors++;
            $display("FAIL reset_values: q=%0d w=%h st=%b we=%b a=%h d=%h sk=%b, required all zero",
                     bus.qPhase, bus.wOut, bus.statusOut, bus.fWrEn, bus.fWrAddr, bus.fWrData, bus.skipReq);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (bus.qPhase !== 2'(i % 4) || bus.fWrEn !== 1'b0) begin
                errors++;
                $display("FAIL sequencer: qPhase=%0d fWrEn=%b, required qPhase=%0d fWrEn=0", bus.qPhase, bus.fWrEn, i % 4);
            end
        end
    endtask

    task automatic test_alu_to_w();
        run_instr("iorlw_w10", FN_IORLW, 1'b0, 5'h00, 8'h10, 3'd0, 1'b0, 0, 1'b0);
        run_instr("addwf_w_zero", FN_ADDWF, 1'b0, 5'h0A, 8'hF0, 3'd0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_file_write();
        run_instr("incf_file", FN_INCF, 1'b1, 5'h07, 8'h41, 3'd0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_status_write();
        run_instr("bcf_status_c", FN_BCF, 1'b1, 5'h03, {5'b0, m_st}, 3'd0, 1'b0, 0, 1'b0);
        run_instr("bsf_status_c", FN_BSF, 1'b1, 5'h03, {5'b0, m_st}, 3'd0, 1'b0, 0, 1'b0);
        run_instr("addwf_status", FN_ADDWF, 1'b1, 5'h03, {5'b0, m_st}, 3'd0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_no_dest();
        run_instr("idle", FN_IDLE, 1'b1, 5'h05, 8'h77, 3'd0, 1'b0, 0, 1'b0);
        run_instr("unknown_fn", 5'd31, 1'b1, 5'h05, 8'h00, 3'd0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_instr("iorlw_w0f", FN_IORLW, 1'b0, 5'h00, 8'h0F, 3'd0, 1'b0, 0, 1'b0);
        run_instr("xorwf_hold", FN_XORWF, 1'b1, 5'h09, 8'h5A, 3'd0, 1'b0, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [16];
        ops = '{FN_ADDWF, FN_SUBWF, FN_ANDWF, FN_COMF, FN_DECF, FN_INCF, FN_IORWF, FN_XORWF,
                FN_ANDLW, FN_IORLW, FN_XORLW, FN_RLF, FN_RRF, FN_SWAPF, FN_BCF, FN_BSF};
        for (int i = 0; i < 16; i++) begin
            run_instr("b2b", ops[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                      3'($urandom_range(0, 7)), 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        run_instr("iorlw_w3c", FN_IORLW, 1'b0, 5'h00, 8'h3C, 3'd0, 1'b0, 0, 1'b0);
        run_instr("addwf_rst_q3", FN_ADDWF, 1'b1, 5'h07, 8'h11, 3'd0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_zero_skip();
        run_instr("decf_skip_zero", FN_DECF, 1'b1, 5'h10, 8'h01, 3'd0, 1'b1, 0, 1'b0);
        @(posedge clk); @(negedge clk);
        checks++;
        if (bus.skipReq !== 1'b0) begin
            errors++;
            $display("FAIL skip_pulse_width: skipReq=%b in Q2, required 0", bus.skipReq);
        end
        run_instr("decf_skip_nonzero", FN_DECF, 1'b1, 5'h10, 8'h02, 3'd0, 1'b1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu_to_w();
        test_file_write();
        test_status_write();
        test_no_dest();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_zero_skip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
